focus_sweep_ctrl: RTL and testbench

Parametrised autofocus engine for the D8M video path: measures a per-frame luma sharpness score inside a programmable window and drives the VCM lens position through a two-phase search. The coarse sweep covers the full range; the fine sweep brackets the best coarse position. It sits between the sync-normalised camera stream (negative-pulse VS) and the VCM I2C writer, and replaces the fixed-window, single-speed step controller.

---
 rtl/focus_sweep_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_focus_sweep_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/focus_sweep_ctrl.sv
// Autofocus engine: windowed luma-gradient sharpness score per frame, driving a
// coarse-then-fine VCM lens sweep that settles on the sharpest position.
module focus_sweep_ctrl #(
    parameter int STEP_W = 10,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 12,
    parameter int COARSE = 32,
    parameter int FINE   = 4
) (
    input  logic              VIDEO_CLK,
    input  logic              RESET_N,
    input  logic              VIDEO_VS,
    input  logic              VIDEO_DE,
    input  logic [7:0]        iY,
    input  logic [CNT_W-1:0]  WIN_X0,
    input  logic [CNT_W-1:0]  WIN_X1,
    input  logic [CNT_W-1:0]  WIN_Y0,
    input  logic [CNT_W-1:0]  WIN_Y1,
    input  logic [3:0]        SETTLE_FRAMES,
    input  logic              START,
    input  logic              ABORT,
    output logic [STEP_W-1:0] STEP,
    output logic [15:0]       VCM_DATA,
    output logic [ACC_W-1:0]  SCORE,
    output logic              SCORE_VALID,
    output logic [STEP_W-1:0] BEST_STEP,
    output logic [ACC_W-1:0]  BEST_SCORE,
    output logic              BUSY,
    output logic              DONE
);

    localparam int               VCM_LSB  = 14 - STEP_W;
    localparam logic [STEP_W:0]  STEP_MAX = {1'b0, {STEP_W{1'b1}}};
    localparam logic [STEP_W:0]  COARSE_C = (STEP_W + 1)'(COARSE);
    localparam logic [STEP_W:0]  FINE_C   = (STEP_W + 1)'(FINE);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_EVAL,
        S_FINISH
    } state_t;

    // ------------------------------------------------------------------
    // Video front end: frame event, raster counters, gradient accumulator
    // ------------------------------------------------------------------
    logic              vs_q_reg;
    logic              fe_reg;
    logic              de_q_reg;
    logic [CNT_W-1:0]  h_reg;
    logic [CNT_W-1:0]  v_reg;
    logic [7:0]        y_reg;
    logic [7:0]        y_prev_reg;
    logic              pix_en_reg;
    logic              pix_first_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [ACC_W-1:0]  score_reg;
    logic              score_valid_reg;

    logic              fe_edge;
    logic              in_win;
    logic [7:0]        grad;
    logic [ACC_W:0]    acc_sum;
    logic [ACC_W-1:0]  acc_sat;

    assign fe_edge = vs_q_reg & ~VIDEO_VS;
    assign in_win  = VIDEO_DE &&
                     (h_reg >= WIN_X0) && (h_reg <= WIN_X1) &&
                     (v_reg >= WIN_Y0) && (v_reg <= WIN_Y1);

    // The first in-window pixel of a line has no in-window neighbour to diff against.
    always_comb begin
        grad = 8'd0;
        if (!pix_first_reg) begin
            grad = (y_reg >= y_prev_reg) ? (y_reg - y_prev_reg) : (y_prev_reg - y_reg);
        end
    end

    assign acc_sum = {1'b0, acc_reg} + {{(ACC_W - 7){1'b0}}, grad};
    assign acc_sat = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];

    always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vs_q_reg        <= 1'b0;
            fe_reg          <= 1'b0;
            de_q_reg        <= 1'b0;
            h_reg           <= '0;
            v_reg           <= '0;
            y_reg           <= '0;
            y_prev_reg      <= '0;
            pix_en_reg      <= 1'b0;
            pix_first_reg   <= 1'b0;
            acc_reg         <= '0;
            score_reg       <= '0;
            score_valid_reg <= 1'b0;
        end else begin
            vs_q_reg      <= VIDEO_VS;
            fe_reg        <= fe_edge;
            de_q_reg      <= VIDEO_DE;
            h_reg         <= VIDEO_DE ? (h_reg + CNT_ONE) : '0;
            pix_en_reg    <= in_win;
            pix_first_reg <= (h_reg == WIN_X0);
            if (fe_edge) begin
                v_reg <= '0;
            end else if (de_q_reg && !VIDEO_DE) begin
                v_reg <= v_reg + CNT_ONE;
            end
            if (VIDEO_DE) begin
                y_reg      <= iY;
                y_prev_reg <= y_reg;
            end
            // Score snapshots the accumulator as it stood before this cycle's pixel.
            if (fe_edge) begin
                score_reg       <= acc_reg;
                score_valid_reg <= 1'b1;
                acc_reg         <= '0;
            end else begin
                score_valid_reg <= 1'b0;
                if (pix_en_reg) begin
                    acc_reg <= acc_sat;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Search FSM
    // ------------------------------------------------------------------
    state_t            state_reg,      state_next;
    logic [3:0]        cnt_reg,        cnt_next;
    logic              phase_reg,      phase_next;
    logic [STEP_W:0]   hi_reg,         hi_next;
    logic [STEP_W:0]   inc_reg,        inc_next;
    logic [STEP_W-1:0] step_reg,       step_next;
    logic [STEP_W-1:0] best_step_reg,  best_step_next;
    logic [ACC_W-1:0]  best_score_reg, best_score_next;
    logic [15:0]       vcm_data_reg,   vcm_data_next;

    logic [STEP_W:0]   step_sum;
    logic [STEP_W:0]   best_ext;
    logic [STEP_W:0]   fine_lo;
    logic [STEP_W:0]   fine_hi_sum;
    logic [STEP_W:0]   fine_hi;

    // All sweep arithmetic is one bit wider than STEP so nothing wraps.
    assign step_sum    = {1'b0, step_reg} + inc_reg;
    assign best_ext    = {1'b0, best_step_reg};
    assign fine_lo     = (best_ext >= COARSE_C) ? (best_ext - COARSE_C) : '0;
    assign fine_hi_sum = best_ext + COARSE_C;
    assign fine_hi     = (fine_hi_sum > STEP_MAX) ? STEP_MAX : fine_hi_sum;

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        phase_next      = phase_reg;
        hi_next         = hi_reg;
        inc_next        = inc_reg;
        step_next       = step_reg;
        best_step_next  = best_step_reg;
        best_score_next = best_score_reg;
        if (ABORT) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (START) begin
                        step_next       = '0;
                        best_score_next = '0;
                        best_step_next  = '0;
                        phase_next      = 1'b0;
                        hi_next         = STEP_MAX;
                        inc_next        = COARSE_C;
                        cnt_next        = 4'd0;
                        state_next      = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (fe_reg) begin
                        if (cnt_reg == SETTLE_FRAMES) begin
                            state_next = S_MEASURE;
                        end else begin
                            cnt_next = cnt_reg + 4'd1;
                        end
                    end
                end
                S_MEASURE: begin
                    if (fe_reg) begin
                        if (score_reg > best_score_reg) begin
                            best_score_next = score_reg;
                            best_step_next  = step_reg;
                        end
                        state_next = S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (step_sum <= hi_reg) begin
                        step_next  = step_sum[STEP_W-1:0];
                        cnt_next   = 4'd0;
                        state_next = S_SETTLE;
                    end else if (!phase_reg) begin
                        // Bracket the best coarse position and rescan it finely.
                        phase_next = 1'b1;
                        inc_next   = FINE_C;
                        hi_next    = fine_hi;
                        step_next  = fine_lo[STEP_W-1:0];
                        cnt_next   = 4'd0;
                        state_next = S_SETTLE;
                    end else begin
                        step_next  = best_step_reg;
                        state_next = S_FINISH;
                    end
                end
                S_FINISH: begin
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // VCM word: two zero MSBs, STEP left-justified in [13:VCM_LSB], zero pad below.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_vcm
            if (gi >= VCM_LSB && gi <= 13) begin : g_step
                assign vcm_data_next[gi] = step_next[gi - VCM_LSB];
            end else begin : g_pad
                assign vcm_data_next[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= 4'd0;
            phase_reg      <= 1'b0;
            hi_reg         <= '0;
            inc_reg        <= '0;
            step_reg       <= '0;
            best_step_reg  <= '0;
            best_score_reg <= '0;
            vcm_data_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            phase_reg      <= phase_next;
            hi_reg         <= hi_next;
            inc_reg        <= inc_next;
            step_reg       <= step_next;
            best_step_reg  <= best_step_next;
            best_score_reg <= best_score_next;
            vcm_data_reg   <= vcm_data_next;
        end
    end

    assign STEP        = step_reg;
    assign VCM_DATA    = vcm_data_reg;
    assign SCORE       = score_reg;
    assign SCORE_VALID = score_valid_reg;
    assign BEST_STEP   = best_step_reg;
    assign BEST_SCORE  = best_score_reg;
    assign BUSY        = (state_reg != S_IDLE);
    assign DONE        = (state_reg == S_FINISH);

endmodule

// File: tb/tb_focus_sweep_ctrl.sv
// Directed bench for focus_sweep_ctrl: scoring, window edges, saturation, closed-loop
// sweeps against a simple lens/scene model, and control corner cases.
module tb_focus_sweep_ctrl;

    localparam int STEP_W = 8;
    localparam int CNT_W  = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              vs;
    logic              de;
    logic [7:0]        y;
    logic [CNT_W-1:0]  wx0, wx1, wy0, wy1;
    logic [3:0]        settle;
    logic              start;
    logic              abort;

    logic [STEP_W-1:0] step, best_step;
    logic [15:0]       vcm;
    logic [31:0]       score, best_score;
    logic              score_valid, busy, done;

    logic [STEP_W-1:0] s_step, s_best_step;
    logic [15:0]       s_vcm;
    logic [7:0]        s_score, s_best_score;
    logic              s_sv, s_busy, s_done;

    always #5 clk = ~clk;

    focus_sweep_ctrl #(.STEP_W(STEP_W), .ACC_W(32), .CNT_W(CNT_W), .COARSE(32), .FINE(4)) u_dut (
        .VIDEO_CLK(clk), .RESET_N(rst_n), .VIDEO_VS(vs), .VIDEO_DE(de), .iY(y),
        .WIN_X0(wx0), .WIN_X1(wx1), .WIN_Y0(wy0), .WIN_Y1(wy1),
        .SETTLE_FRAMES(settle), .START(start), .ABORT(abort),
        .STEP(step), .VCM_DATA(vcm), .SCORE(score), .SCORE_VALID(score_valid),
        .BEST_STEP(best_step), .BEST_SCORE(best_score), .BUSY(busy), .DONE(done)
    );

    // Narrow-accumulator twin used only to observe saturation.
    focus_sweep_ctrl #(.STEP_W(STEP_W), .ACC_W(8), .CNT_W(CNT_W), .COARSE(32), .FINE(4)) u_sat (
        .VIDEO_CLK(clk), .RESET_N(rst_n), .VIDEO_VS(vs), .VIDEO_DE(de), .iY(y),
        .WIN_X0(wx0), .WIN_X1(wx1), .WIN_Y0(wy0), .WIN_Y1(wy1),
        .SETTLE_FRAMES(settle), .START(1'b0), .ABORT(1'b0),
        .STEP(s_step), .VCM_DATA(s_vcm), .SCORE(s_score), .SCORE_VALID(s_sv),
        .BEST_STEP(s_best_step), .BEST_SCORE(s_best_score), .BUSY(s_busy), .DONE(s_done)
    );

    int compared   = 0;
    int mismatched = 0;
    int scene_mode = 0;

    int sv_cnt   = 0;
    int done_cnt = 0;
    int busy_fe  = 0;
    logic              busy_prev = 1'b0;
    logic [STEP_W-1:0] step_prev = '0;
    logic [STEP_W-1:0] trace[$];

    always @(negedge clk) begin
        if (score_valid)         sv_cnt   <= sv_cnt + 1;
        if (done)                done_cnt <= done_cnt + 1;
        if (busy && score_valid) busy_fe  <= busy_fe + 1;
        if (busy && (!busy_prev || step != step_prev)) trace.push_back(step);
        busy_prev <= busy;
        step_prev <= step;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic vs_pulse(input bit start_on_fe);
        @(negedge clk); vs = 1'b0;
        @(negedge clk); start = start_on_fe;
        @(negedge clk); start = 1'b0; vs = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    logic [7:0] lbuf[0:31];
    int llen;

    task automatic send_line();
        for (int i = 0; i < llen; i++) begin
            @(negedge clk); de = 1'b1; y = lbuf[i];
        end
        @(negedge clk); de = 1'b0; y = 8'd0;
        repeat (3) @(negedge clk);
    endtask

    function automatic int amp(input int mode, input int s);
        int d;
        if (mode == 0) begin
            d = (s > 70) ? s - 70 : 70 - s;
            return (d > 120) ? 0 : 120 - d;
        end
        return (s == 8 || s == 12) ? 100 : ((s == 0) ? 50 : 10);
    endfunction

    // One camera frame: frame event, then a 4-pixel line 0,a,0,a scoring 3a.
    task automatic scene_frame(input bit start_on_fe);
        int a;
        vs_pulse(start_on_fe);
        a = amp(scene_mode, int'(step));
        llen = 4;
        lbuf[0] = 8'd0; lbuf[1] = 8'(a); lbuf[2] = 8'd0; lbuf[3] = 8'(a);
        send_line();
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_abort();
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vs = 1'b1; de = 1'b0; y = 8'd0; start = 1'b0; abort = 1'b0;
        settle = 4'd0; wx0 = 0; wx1 = 3; wy0 = 0; wy1 = 0;
        repeat (3) @(negedge clk);
        compared++; if (step !== 8'd0) begin mismatched++; $display("FAIL reset_step: got %0d expected 0", step); end
        compared++; if (vcm !== 16'd0) begin mismatched++; $display("FAIL reset_vcm: got %h expected 0000", vcm); end
        compared++; if (score !== 32'd0 || score_valid !== 1'b0) begin mismatched++; $display("FAIL reset_score: got %0d/%b expected 0/0", score, score_valid); end
        compared++; if (best_step !== 8'd0 || best_score !== 32'd0) begin mismatched++; $display("FAIL reset_best: got %0d/%0d expected 0/0", best_step, best_score); end
        compared++; if (busy !== 1'b0 || done !== 1'b0) begin mismatched++; $display("FAIL reset_busy_done: got %b/%b expected 0/0", busy, done); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_scoring();
        int sv0;
        wx0 = 0; wx1 = 3; wy0 = 0; wy1 = 0;
        vs_pulse(1'b0);
        sv0 = sv_cnt;
        llen = 4; lbuf[0] = 8'd10; lbuf[1] = 8'd30; lbuf[2] = 8'd20; lbuf[3] = 8'd20;
        send_line();
        @(negedge clk); vs = 1'b0;
        @(negedge clk);
        compared++; if (score_valid !== 1'b1 || score !== 32'd30) begin mismatched++; $display("FAIL score_on_fe: got valid=%b score=%0d expected valid=1 score=30", score_valid, score); end
        @(negedge clk); vs = 1'b1;
        compared++; if (score_valid !== 1'b0) begin mismatched++; $display("FAIL score_valid_width: got %b expected 0", score_valid); end
        repeat (3) @(negedge clk);
        compared++; if (sv_cnt - sv0 !== 1) begin mismatched++; $display("FAIL score_valid_count: got %0d expected 1", sv_cnt - sv0); end
        vs_pulse(1'b0);
        compared++; if (score !== 32'd0) begin mismatched++; $display("FAIL acc_clear: got %0d expected 0", score); end
    endtask

    task automatic test_window_edges();
        wx0 = 1; wx1 = 2; wy0 = 1; wy1 = 1;
        vs_pulse(1'b0);
        llen = 4; lbuf[0] = 8'd0; lbuf[1] = 8'd200; lbuf[2] = 8'd0; lbuf[3] = 8'd200;
        send_line();
        lbuf[0] = 8'd0; lbuf[1] = 8'd50; lbuf[2] = 8'd100; lbuf[3] = 8'd250;
        send_line();
        vs_pulse(1'b0);
        compared++; if (score !== 32'd50) begin mismatched++; $display("FAIL window_edges: got %0d expected 50", score); end
    endtask

    task automatic test_saturation();
        wx0 = 0; wx1 = 30; wy0 = 0; wy1 = 0;
        vs_pulse(1'b0);
        llen = 21;
        for (int i = 0; i < 21; i++) lbuf[i] = (i % 2 == 1) ? 8'd255 : 8'd0;
        send_line();
        vs_pulse(1'b0);
        compared++; if (score !== 32'd5100) begin mismatched++; $display("FAIL wide_acc: got %0d expected 5100", score); end
        compared++; if (s_score !== 8'd255) begin mismatched++; $display("FAIL saturation: got %0d expected 255", s_score); end
    endtask

    // Runs a full closed-loop search and checks the visited positions and outcome.
    task automatic run_search(input int mode, input int lo_fine, input int hi_fine,
                              input int exp_step, input int exp_score, input int exp_fe,
                              input int nsettle);
        int t0, d0, f0, n, bad;
        logic [STEP_W-1:0] expq[$];
        expq = {};
        for (int s = 0; s <= 224; s += 32) expq.push_back(8'(s));
        for (int s = lo_fine; s <= hi_fine; s += 4) expq.push_back(8'(s));
        expq.push_back(8'(exp_step));
        wx0 = 0; wx1 = 3; wy0 = 0; wy1 = 0;
        settle = 4'(nsettle); scene_mode = mode;
        t0 = trace.size(); d0 = done_cnt; f0 = busy_fe;
        pulse_start();
        for (int f = 0; f < 200 && done_cnt == d0; f++) scene_frame(1'b0);
        repeat (3) @(negedge clk);
        compared++; if (done_cnt - d0 !== 1) begin mismatched++; $display("FAIL search_done_m%0d: got %0d pulses expected 1", mode, done_cnt - d0); end
        n = trace.size() - t0;
        compared++; if (n !== expq.size()) begin mismatched++; $display("FAIL search_len_m%0d: got %0d positions expected %0d", mode, n, expq.size()); end
        bad = -1;
        for (int i = 0; i < n && i < expq.size(); i++) if (bad < 0 && trace[t0 + i] !== expq[i]) bad = i;
        compared++; if (bad >= 0) begin mismatched++; $display("FAIL search_path_m%0d: got %0d at index %0d expected %0d", mode, trace[t0 + bad], bad, expq[bad]); end
        compared++; if (step !== 8'(exp_step) || best_step !== 8'(exp_step)) begin mismatched++; $display("FAIL search_step_m%0d: got %0d/%0d expected %0d", mode, step, best_step, exp_step); end
        compared++; if (vcm !== {2'b00, 8'(exp_step), 6'b0}) begin mismatched++; $display("FAIL search_vcm_m%0d: got %h expected %h", mode, vcm, {2'b00, 8'(exp_step), 6'b0}); end
        compared++; if (best_score !== 32'(exp_score)) begin mismatched++; $display("FAIL search_score_m%0d: got %0d expected %0d", mode, best_score, exp_score); end
        compared++; if (busy_fe - f0 !== exp_fe || busy !== 1'b0) begin mismatched++; $display("FAIL search_frames_m%0d: got %0d frames busy=%b expected %0d busy=0", mode, busy_fe - f0, busy, exp_fe); end
    endtask

    task automatic test_full_search();
        run_search(0, 32, 96, 68, 354, 75, 1);
    endtask

    task automatic test_clamp_ties();
        run_search(1, 0, 32, 8, 300, 34, 0);
    endtask

    task automatic test_abort();
        int d0;
        settle = 4'd0; scene_mode = 0; d0 = done_cnt;
        pulse_start();
        scene_frame(1'b0); scene_frame(1'b0);
        compared++; if (step !== 8'd32 || busy !== 1'b1) begin mismatched++; $display("FAIL abort_pre: got step=%0d busy=%b expected 32/1", step, busy); end
        pulse_abort();
        compared++; if (busy !== 1'b0 || step !== 8'd32) begin mismatched++; $display("FAIL abort_idle: got busy=%b step=%0d expected 0/32", busy, step); end
        scene_frame(1'b0); scene_frame(1'b0);
        compared++; if (busy !== 1'b0 || step !== 8'd32 || done_cnt !== d0) begin mismatched++; $display("FAIL abort_hold: got busy=%b step=%0d done=%0d expected 0/32/0", busy, step, done_cnt - d0); end
        @(negedge clk); abort = 1'b1; start = 1'b1;
        @(negedge clk); abort = 1'b0; start = 1'b0;
        @(negedge clk);
        compared++; if (busy !== 1'b0 || step !== 8'd32) begin mismatched++; $display("FAIL abort_beats_start: got busy=%b step=%0d expected 0/32", busy, step); end
    endtask

    task automatic test_start_busy();
        settle = 4'd0; scene_mode = 0;
        pulse_start();
        scene_frame(1'b0); scene_frame(1'b0);
        pulse_start();
        @(negedge clk);
        compared++; if (step !== 8'd32 || busy !== 1'b1) begin mismatched++; $display("FAIL start_busy_ignored: got step=%0d busy=%b expected 32/1", step, busy); end
        scene_frame(1'b0); scene_frame(1'b0);
        compared++; if (step !== 8'd64) begin mismatched++; $display("FAIL start_busy_continue: got %0d expected 64", step); end
        pulse_abort();
    endtask

    task automatic test_start_on_fe();
        settle = 4'd0; scene_mode = 0;
        scene_frame(1'b1);
        compared++; if (busy !== 1'b1 || step !== 8'd0) begin mismatched++; $display("FAIL start_fe_begin: got busy=%b step=%0d expected 1/0", busy, step); end
        scene_frame(1'b0);
        compared++; if (step !== 8'd0) begin mismatched++; $display("FAIL start_fe_extra: got %0d expected 0", step); end
        scene_frame(1'b0);
        compared++; if (step !== 8'd32) begin mismatched++; $display("FAIL start_fe_move: got %0d expected 32", step); end
        pulse_abort();
    endtask

    task automatic test_reset_mid_measure();
        int d0;
        settle = 4'd0; scene_mode = 0;
        pulse_start();
        scene_frame(1'b0); scene_frame(1'b0); scene_frame(1'b0);
        compared++; if (busy !== 1'b1 || step !== 8'd32 || best_score !== 32'd150) begin mismatched++; $display("FAIL measure_pre: got busy=%b step=%0d best=%0d expected 1/32/150", busy, step, best_score); end
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        compared++; if (step !== 8'd0 || vcm !== 16'd0 || busy !== 1'b0 || done !== 1'b0) begin mismatched++; $display("FAIL async_reset_ctrl: got step=%0d vcm=%h busy=%b done=%b expected 0", step, vcm, busy, done); end
        compared++; if (score !== 32'd0 || best_score !== 32'd0 || best_step !== 8'd0 || score_valid !== 1'b0) begin mismatched++; $display("FAIL async_reset_score: got %0d/%0d/%0d/%b expected 0", score, best_score, best_step, score_valid); end
        @(negedge clk); rst_n = 1'b1;
        d0 = done_cnt;
        scene_frame(1'b0); scene_frame(1'b0);
        compared++; if (busy !== 1'b0 || step !== 8'd0 || done_cnt !== d0) begin mismatched++; $display("FAIL post_reset_idle: got busy=%b step=%0d done=%0d expected 0/0/0", busy, step, done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_scoring();
        test_window_edges();
        test_saturation();
        test_full_search();
        test_clamp_ties();
        test_abort();
        test_start_busy();
        test_start_on_fe();
        test_reset_mid_measure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
